// File: rtl/montgomery_modexp_engine_if.sv
// Request/result handshake bundle for montgomery_modexp_engine.
// master = requester/consumer, slave = engine.
interface montgomery_modexp_engine_if #(
  parameter int WORD_WIDTH = 32,
  parameter int EXP_WIDTH  = 32
);
  logic                  start_valid;
  logic                  start_ready;
  logic [WORD_WIDTH-1:0] m;
  logic [WORD_WIDTH-1:0] x;
  logic [EXP_WIDTH-1:0]  e;
  logic [WORD_WIDTH-1:0] r2_mod_m;
  logic                  res_valid;
  logic                  res_ready;
  logic [WORD_WIDTH-1:0] result;
  logic                  err;

  modport master (
    output start_valid, m, x, e, r2_mod_m, res_ready,
    input  start_ready, res_valid, result, err
  );

  modport slave (
    input  start_valid, m, x, e, r2_mod_m, res_ready,
    output start_ready, res_valid, result, err
  );
endinterface

// File: rtl/montgomery_modexp_engine.sv
// x^e mod m by left-to-right square-and-multiply over a bit-serial radix-2 Montgomery multiplier.
// Optional MODEXP_CONST_TIME_EN: fixed-latency schedule (no SCAN, MULT on every bit).
module montgomery_modexp_engine #(
  parameter int WORD_WIDTH = 32,
  parameter int EXP_WIDTH  = 32
) (
  input  logic clk,
  input  logic reset_n,
  montgomery_modexp_engine_if.slave bus
);
  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int BW = $clog2(EXP_WIDTH);

  typedef enum logic [2:0] {IDLE, PRE_X, PRE_A, SCAN, SQUARE, MULT, FINAL, DONE} state_t;

  state_t state, state_nx;

  logic [WORD_WIDTH-1:0] m_r, x_r, r2_r, x_t, a_r, result_r;
  logic [EXP_WIDTH-1:0]  esh;
  logic [BW-1:0]         bidx;
  logic                  err_r;

  logic [WORD_WIDTH+1:0] acc, acc_nx;
  logic [CW-1:0]         cnt;
  logic [WORD_WIDTH-1:0] mm_a, mm_b, mm_res, a_sh;
  logic [WORD_WIDTH+2:0] s1, s2;
  logic                  mm_busy, mm_done, a_bit, acc_ge;
  logic                  cur_bit, bit_last, accept;
  logic                  esh_shift, a_load, xt_load, res_load;
  logic                  unused_bits;

  assign accept   = (state == IDLE) && bus.start_valid;
  assign cur_bit  = esh[EXP_WIDTH-1];
  assign bit_last = (bidx == '0);

  // Operand routing: the multiplier runs whenever the FSM sits in an MM state.
  always_comb begin
    mm_a    = '0;
    mm_b    = '0;
    mm_busy = 1'b1;
    case (state)
      PRE_X:  begin mm_a = x_r;                 mm_b = r2_r; end
      PRE_A:  begin mm_a = WORD_WIDTH'(1);      mm_b = r2_r; end
      SQUARE: begin mm_a = a_r;                 mm_b = a_r;  end
      MULT:   begin mm_a = a_r;                 mm_b = x_t;  end
      FINAL:  begin mm_a = a_r;                 mm_b = WORD_WIDTH'(1); end
      default: mm_busy = 1'b0;
    endcase
  end

  assign mm_done = mm_busy && (cnt == CW'(WORD_WIDTH));

  // One radix-2 step: add a_i*b, make even with q*m, halve.
  always_comb begin
    a_sh   = mm_a >> cnt;
    a_bit  = a_sh[0];
    s1     = {1'b0, acc} + (a_bit ? {3'b0, mm_b} : '0);
    s2     = s1 + (s1[0] ? {3'b0, m_r} : '0);
    acc_nx = s2[WORD_WIDTH+2:1];
    acc_ge = (acc >= {2'b0, m_r});
    mm_res = acc_ge ? (acc[WORD_WIDTH-1:0] - m_r) : acc[WORD_WIDTH-1:0];
  end

  assign unused_bits = ^{s2[0], a_sh[WORD_WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (!mm_busy || mm_done) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    esh_shift = 1'b0;
    a_load    = 1'b0;
    xt_load   = 1'b0;
    res_load  = 1'b0;
    case (state)
      IDLE:  if (bus.start_valid) state_nx = bus.m[0] ? PRE_X : DONE;
      PRE_X: if (mm_done) begin
        xt_load  = 1'b1;
        state_nx = PRE_A;
      end
      PRE_A: if (mm_done) begin
        a_load = 1'b1;
`ifdef MODEXP_CONST_TIME_EN
        state_nx = SQUARE;
`else
        state_nx = SCAN;
`endif
      end
      SCAN: begin
        if (cur_bit)       state_nx = SQUARE;
        else if (bit_last) state_nx = FINAL;
        else               esh_shift = 1'b1;
      end
      SQUARE: if (mm_done) begin
        a_load = 1'b1;
`ifdef MODEXP_CONST_TIME_EN
        state_nx = MULT;
`else
        if (cur_bit)       state_nx = MULT;
        else if (bit_last) state_nx = FINAL;
        else               esh_shift = 1'b1;
`endif
      end
      // A is only replaced when the bit is set; the dummy product is dropped otherwise.
      MULT: if (mm_done) begin
        a_load = cur_bit;
        if (bit_last) state_nx = FINAL;
        else begin
          state_nx  = SQUARE;
          esh_shift = 1'b1;
        end
      end
      FINAL: if (mm_done) begin
        res_load = 1'b1;
        state_nx = DONE;
      end
      DONE:    if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_r      <= '0;
      x_r      <= '0;
      r2_r     <= '0;
      x_t      <= '0;
      a_r      <= '0;
      esh      <= '0;
      bidx     <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      if (accept) begin
        m_r      <= bus.m;
        x_r      <= bus.x;
        r2_r     <= bus.r2_mod_m;
        esh      <= bus.e;
        bidx     <= BW'(EXP_WIDTH - 1);
        result_r <= '0;
        err_r    <= ~bus.m[0];
      end
      if (xt_load)   x_t <= mm_res;
      if (a_load)    a_r <= mm_res;
      if (res_load)  result_r <= mm_res;
      if (esh_shift) begin
        esh  <= {esh[EXP_WIDTH-2:0], 1'b0};
        bidx <= bidx - 1'b1;
      end
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.result      = result_r;
  assign bus.err         = err_r;
endmodule

// File: tb/tb_montgomery_modexp_engine.sv
// Randomized self-checking bench for montgomery_modexp_engine against a plain-arithmetic model.
module tb_montgomery_modexp_engine;
  localparam int W   = 8;
  localparam int EW  = 8;
  localparam int L   = W + 1;
  localparam int BUD = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  montgomery_modexp_engine_if #(.WORD_WIDTH(W), .EXP_WIDTH(EW)) bus ();

  montgomery_modexp_engine #(.WORD_WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int ref_modexp(int m, int x, int e);
    longint r;
    r = 1 % m;
    repeat (e) r = (r * x) % m;
    return int'(r);
  endfunction

  function automatic int ref_lat(int m, int e);
    int k, p, lat;
    k = 0; p = 0;
    for (int i = 0; i < EW; i++) if (((e >> i) & 1) == 1) begin k = i; p++; end
`ifdef MODEXP_CONST_TIME_EN
    lat = L * (3 + 2 * EW) + 1;
`else
    if (e == 0) lat = 3 * L + EW + 1;
    else        lat = L * (3 + (k + 1) + p) + (EW - k) + 1;
`endif
    if (m % 2 == 0) lat = 1;
    return lat;
  endfunction

  // Issues one request and waits for res_valid; lat counts accept edge as cycle 1.
  task automatic run_req(input int m, input int x, input int e, input int r2, input bit poke,
                         output int res, output bit er, output int lat);
    @(negedge clk);
    bus.m = W'(m); bus.x = W'(x); bus.e = EW'(e); bus.r2_mod_m = W'(r2);
    bus.start_valid = 1'b1;
    lat = 0;
    while (!bus.start_ready && lat < BUD) begin @(negedge clk); lat++; end
    @(posedge clk); #1;
    bus.start_valid = poke;
    bus.m = W'($urandom); bus.x = W'($urandom); bus.e = EW'($urandom); bus.r2_mod_m = W'($urandom);
    lat = 1;
    while (!bus.res_valid && lat < BUD) begin
      @(posedge clk); #1; lat++;
      if (lat == 20) bus.start_valid = 1'b0;
    end
    bus.start_valid = 1'b0;
    res = int'(bus.result);
    er  = bus.err;
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.result !== '0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b res=%0d err=%b want 1 0 0 0",
               bus.start_ready, bus.res_valid, bus.result, bus.err);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int res, lat; bit er;
    run_req(13, 4, 5, 3, 1'b0, res, er, lat);
    n_tests++;
    if (res !== 10 || er !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got %0d err=%b want 10 err=0", res, er);
    end
    n_tests++;
    if (lat !== ref_lat(13, 5)) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, ref_lat(13, 5));
    end
    ack();
    n_tests++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: rdy=%b vld=%b want 1 0", bus.start_ready, bus.res_valid);
    end
  endtask

  task automatic test_edge_values();
    int res, lat; bit er;
    run_req(13, 7, 0, 3, 1'b0, res, er, lat);
    n_tests++;
    if (res !== 1 || lat !== ref_lat(13, 0)) begin
      n_fail++; $display("FAIL e_zero: got %0d lat %0d want 1 lat %0d", res, lat, ref_lat(13, 0));
    end
    ack();
    run_req(1, 0, 3, 0, 1'b0, res, er, lat);
    n_tests++;
    if (res !== 0 || er !== 1'b0 || lat !== ref_lat(1, 3)) begin
      n_fail++; $display("FAIL m_one: got %0d err=%b lat %0d want 0 0 lat %0d", res, er, lat, ref_lat(1, 3));
    end
    ack();
  endtask

  task automatic test_even_m();
    int res, lat; bit er;
    run_req(12, 5, 3, 0, 1'b0, res, er, lat);
    n_tests++;
    if (er !== 1'b1 || res !== 0 || lat !== 1) begin
      n_fail++; $display("FAIL even_m: err=%b res=%0d lat=%0d want 1 0 1", er, res, lat);
    end
    ack();
    n_tests++;
    if (bus.start_ready !== 1'b1) begin
      n_fail++; $display("FAIL even_m_ready: got %b want 1", bus.start_ready);
    end
  endtask

  task automatic test_fermat_hold();
    int res, lat; bit er;
    run_req(251, 2, 250, 25, 1'b0, res, er, lat);
    n_tests++;
    if (res !== 1 || lat !== ref_lat(251, 250)) begin
      n_fail++; $display("FAIL fermat: got %0d lat %0d want 1 lat %0d", res, lat, ref_lat(251, 250));
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.res_valid !== 1'b1 || bus.result !== W'(1)) begin
        n_fail++; $display("FAIL hold_stable: cyc %0d vld=%b res=%0d want 1 1", i, bus.res_valid, bus.result);
      end
    end
    ack();
  endtask

  task automatic test_busy_ignored();
    int res, lat; bit er; bit seen;
    run_req(13, 4, 5, 3, 1'b1, res, er, lat);
    n_tests++;
    if (res !== 10 || lat !== ref_lat(13, 5)) begin
      n_fail++; $display("FAIL busy_ignored: got %0d lat %0d want 10 lat %0d", res, lat, ref_lat(13, 5));
    end
    ack();
    seen = 1'b0;
    repeat (60) begin @(posedge clk); #1; if (bus.res_valid) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL no_queue: spurious res_valid %b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int res, lat, m, x, e; bit er;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m = 2 * $urandom_range(0, 127) + 1;
      x = $urandom_range(0, m - 1);
      e = $urandom_range(0, 255);
      run_req(m, x, e, 65536 % m, 1'b0, res, er, lat);
      n_tests++;
      if (res !== ref_modexp(m, x, e) || lat !== ref_lat(m, e)) begin
        n_fail++; $display("FAIL b2b_result: m=%0d x=%0d e=%0d got %0d lat %0d want %0d lat %0d",
                           m, x, e, res, lat, ref_modexp(m, x, e), ref_lat(m, e));
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_no_stall: vld=%b rdy=%b want 0 1", bus.res_valid, bus.start_ready);
      end
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_midop_reset();
    int res, lat; bit er; bit seen;
    @(negedge clk);
    bus.m = 8'd13; bus.x = 8'd4; bus.e = 8'd5; bus.r2_mod_m = 8'd3;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: rdy=%b vld=%b want 1 0", bus.start_ready, bus.res_valid);
    end
    #3 reset_n = 1'b1;
    seen = 1'b0;
    repeat (100) begin @(posedge clk); #1; if (bus.res_valid) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midop_abort: res_valid seen %b want 0", seen);
    end
    run_req(13, 4, 5, 3, 1'b0, res, er, lat);
    n_tests++;
    if (res !== 10 || er !== 1'b0) begin
      n_fail++; $display("FAIL midop_recover: got %0d err=%b want 10 0", res, er);
    end
    ack();
  endtask

  task automatic test_random();
    int res, lat, m, x, e, exp_res; bit er, exp_er;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) m = 2 * $urandom_range(1, 127);
      else                           m = 2 * $urandom_range(0, 127) + 1;
      x = $urandom_range(0, m - 1);
      e = $urandom_range(0, 255);
      exp_er  = (m % 2 == 0);
      exp_res = exp_er ? 0 : ref_modexp(m, x, e);
      run_req(m, x, e, 65536 % m, 1'b0, res, er, lat);
      n_tests++;
      if (res !== exp_res || er !== exp_er || lat !== ref_lat(m, e)) begin
        n_fail++; $display("FAIL random: m=%0d x=%0d e=%0d got %0d err=%b lat %0d want %0d err=%b lat %0d",
                           m, x, e, res, er, lat, exp_res, exp_er, ref_lat(m, e));
      end
      ack();
    end
  endtask

  initial begin
    bus.start_valid = 1'b0; bus.res_ready = 1'b0;
    bus.m = '0; bus.x = '0; bus.e = '0; bus.r2_mod_m = '0;
    test_reset();
    test_basic();
    test_edge_values();
    test_even_m();
    test_fermat_hold();
    test_busy_ignored();
    test_back_to_back();
    test_midop_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
